uart_rx_param: RTL and testbench

Parametrised UART receiver; successor to the fixed 8N1 receiver in the audio streaming path.
- Configurable data width, parity mode, stop-bit count and bit period.
- Input synchroniser with 3-sample majority vote.
- False-start rejection, framing/parity error and break detection.
- Valid/ready output handshake with overrun reporting.
- Sits between the board UART pin and the sample assembler/audio buffer.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_param.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity encodings,
// receiver FSM states and the mid-bit offset helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    function automatic int unsigned half_period(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser on the raw serial line plus a 3-sample
// majority filter over the synchronised stream.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic rx_s,
    output logic rx_maj
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    // window is the current rx_s and the two values before it
    assign rx_maj = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit majority sampling, false-start
// rejection, parity/framing/break detection and a valid/ready output.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 59,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int unsigned     CW     = $clog2(CLKS_PER_BIT);
    localparam int unsigned     HALF   = half_period(CLKS_PER_BIT);
    localparam logic [CW-1:0]   HALF_C = CW'(HALF);
    localparam logic [CW-1:0]   LAST_C = CW'(CLKS_PER_BIT - 1);

    logic rx_s, rx_maj;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .rx_s    (rx_s),
        .rx_maj  (rx_maj)
    );

    rx_state_t              state_q, state_n;
    logic [CW-1:0]          cnt_q, cnt_n, cnt_wrap;
    logic [3:0]             idx_q, idx_n;
    logic [DATA_BITS-1:0]   shreg_q, shreg_n;
    logic                   par_q, par_n;
    logic                   ferr_q, ferr_n, ferr_fin;
    logic                   load_q, load_n;
    logic                   brk_n;
    logic                   perr;

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        idx_n    = idx_q;
        shreg_n  = shreg_q;
        par_n    = par_q;
        ferr_n   = ferr_q;
        load_n   = 1'b0;
        brk_n    = 1'b0;
        cnt_wrap = (cnt_q == LAST_C) ? '0 : cnt_q + CW'(1);
        ferr_fin = ferr_q | ~rx_maj;
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                cnt_n = cnt_wrap;
                if (cnt_q == HALF_C) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    ferr_n  = 1'b0;
                    state_n = rx_maj ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_n = cnt_wrap;
                if (cnt_q == LAST_C) begin
                    shreg_n = {rx_maj, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == 4'(DATA_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end else begin
                        idx_n = idx_q + 4'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                cnt_n = cnt_wrap;
                if (cnt_q == LAST_C) begin
                    par_n   = rx_maj;
                    state_n = STOP;
                end
            end
            STOP: begin
                cnt_n = cnt_wrap;
                if (cnt_q == LAST_C) begin
                    ferr_n = ferr_fin;
                    if (idx_q == 4'(STOP_BITS - 1)) begin
                        idx_n = '0;
                        if (shreg_q == '0 && (PARITY == PAR_NONE || !par_q) && ferr_fin) begin
                            brk_n   = 1'b1;
                            state_n = BREAK_WAIT;
                        end else begin
                            load_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n = idx_q + 4'd1;
                    end
                end
            end
            BREAK_WAIT: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        perr = 1'b0;
        if (PARITY == PAR_ODD)  perr = ~(^shreg_q ^ par_q);
        if (PARITY == PAR_EVEN) perr = ^shreg_q ^ par_q;
    end

    // shreg/ferr stay untouched in IDLE, so the load one cycle after the
    // last stop sample still sees this frame's values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            load_q     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            shreg_q   <= shreg_n;
            par_q     <= par_n;
            ferr_q    <= ferr_n;
            load_q    <= load_n;
            break_det <= brk_n;
            overrun   <= 1'b0;
            if (data_valid && data_ready) data_valid <= 1'b0;
            if (load_q) begin
                data_out   <= shreg_q;
                frame_err  <= ferr_q;
                parity_err <= perr;
                data_valid <= 1'b1;
                overrun    <= data_valid && !data_ready;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an even-parity
// instance, with expected words queued at send time and popped on acceptance.
module tb_uart_rx_param;

    localparam int unsigned CPB = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx0, rx1, rdy0, rdy1;
    logic [7:0] d0, d1;
    logic       dv0, dv1, fe0, fe1, pe0, pe1, ov0, ov1, bk0, bk1, busy0, busy1;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   acc0 = 0, acc1 = 0, vcyc0 = 0, ovr0 = 0, brk0 = 0;
    int   a, b, c;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx0), .data_out(d0), .data_valid(dv0),
        .data_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
        .break_det(bk0), .busy(busy0)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx1), .data_out(d1), .data_valid(dv1),
        .data_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
        .break_det(bk1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv0) vcyc0++;
            if (ov0) ovr0++;
            if (bk0) brk0++;
            if (dv0 && rdy0) begin
                acc0++;
                e0 = (q0.size() != 0) ? q0.pop_front() : exp_t'('1);
                check("word0", {22'd0, d0, fe0, pe0}, {22'd0, e0});
            end
            if (dv1 && rdy1) begin
                acc1++;
                e1 = (q1.size() != 0) ? q1.pop_front() : exp_t'('1);
                check("word1", {22'd0, d1, fe1, pe1}, {22'd0, e1});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    task automatic send_bit(input int which, input logic v, input bit glitch);
        drive(which, v);
        if (glitch) begin
            tick(8);
            drive(which, ~v);
            tick(1);
            drive(which, v);
            tick(CPB - 9);
        end else begin
            tick(CPB);
        end
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic p, input logic stop, input int gbit);
        send_bit(which, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, d[i], i == gbit);
        if (has_par) send_bit(which, p, 1'b0);
        send_bit(which, stop, 1'b0);
        drive(which, 1'b1);
    endtask

    task automatic drain(input int which, input string tag);
        for (int i = 0; i < 200; i++) begin
            if ((which == 0 ? q0.size() : q1.size()) == 0) break;
            tick(1);
        end
        check(tag, which == 0 ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
        tick(3);
        check("rst_data_out", d0, 0);
        check("rst_valid", dv0, 0);
        check("rst_frame_err", fe0, 0);
        check("rst_parity_err", pe0, 0);
        check("rst_overrun", ov0, 0);
        check("rst_break", bk0, 0);
        check("rst_busy", busy0, 0);
        check("rst_valid_p", dv1, 0);
        rst_n = 1'b1;
        tick(5);

        // plain 8N1 word, consumer always ready
        b = vcyc0;
        q0.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
        tick(CPB);
        drain(0, "a5_drain");
        check("a5_valid_cycles", vcyc0 - b, 1);

        // even parity: 0x3C has even weight, so parity bit 1 is wrong
        q1.push_back({8'h3C, 1'b0, 1'b1});
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, -1);
        tick(CPB);
        drain(1, "par_bad_drain");
        q1.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, -1);
        tick(CPB);
        drain(1, "par_ok_drain");

        // short low glitch on idle line is a false start
        a = acc0;
        rx0 = 1'b0;
        tick(4);
        check("glitch_busy_hi", busy0, 1);
        rx0 = 1'b1;
        tick(2 * CPB);
        check("glitch_busy_lo", busy0, 0);
        check("glitch_no_word", acc0, a);
        check("glitch_valid", dv0, 0);

        // single-cycle glitch inside a data bit is voted out
        q0.push_back({8'h55, 1'b0, 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 3);
        tick(CPB);
        drain(0, "glitch55_drain");

        // stop bit low with non-zero data is a framing error, not a break
        b = brk0;
        q0.push_back({8'h12, 1'b1, 1'b0});
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b0, -1);
        tick(3 * CPB);
        drain(0, "ferr_drain");
        check("ferr_no_break", brk0, b);

        // break: line low for 20 bit periods
        a = acc0; b = brk0;
        rx0 = 1'b0;
        tick(20 * CPB);
        check("brk_busy_wait", busy0, 1);
        rx0 = 1'b1;
        tick(3 * CPB);
        check("brk_pulse", brk0 - b, 1);
        check("brk_no_word", acc0, a);
        check("brk_busy_lo", busy0, 0);
        q0.push_back({8'h81, 1'b0, 1'b0});
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
        tick(CPB);
        drain(0, "after_brk_drain");

        // overrun: consumer stalled across two frames
        rdy0 = 1'b0;
        b = ovr0;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
        tick(CPB);
        check("ovr_first_none", ovr0, b);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
        tick(CPB);
        check("ovr_pulse", ovr0 - b, 1);
        check("ovr_valid", dv0, 1);
        check("ovr_data", d0, 8'h22);
        q0.push_back({8'h22, 1'b0, 1'b0});
        rdy0 = 1'b1;
        drain(0, "ovr_drain");
        tick(2);
        check("ovr_valid_clr", dv0, 0);

        // reset in the middle of a data bit abandons the frame
        b = brk0; c = ovr0;
        send_bit(0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        tick(CPB / 2);
        rst_n = 1'b0;
        rx0 = 1'b1;
        tick(2);
        check("midrst_busy", busy0, 0);
        check("midrst_valid", dv0, 0);
        rst_n = 1'b1;
        tick(2 * CPB);
        a = acc0;
        q0.push_back({8'h7E, 1'b0, 1'b0});
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, -1);
        tick(CPB);
        drain(0, "midrst_drain");
        check("midrst_one_word", acc0 - a, 1);
        check("midrst_no_break", brk0, b);
        check("midrst_no_ovr", ovr0, c);

        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
